ex_stage_p: RTL and testbench
=============================

EX_STAGE_P -- requirements
Module: ex_stage_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: datapath, PC and immediate width (≥4).
REQ-002 SHALL have parameter RD_W, default 2: destination register index width.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid  in  1 / in_ready  out  1: upstream beat handshake.
REQ-006 SHALL have ports pc, reg_val, imm  in  DATA_W each: PC, register operand, sign-extended immediate.
REQ-007 SHALL have ports funct  in  3  ALU op; rd_in  in  RD_W  destination index.
REQ-008 SHALL have ports sin, ina, sout  in  1 each: immediate select, input-accumulator load, output-accumulator/zero load.
REQ-009 SHALL have port ctrl_in  in  6  {wr,wm,rm,neq,j,jc} pass-through controls.
REQ-010 SHALL have port flush  in  1: synchronous pipeline kill.
REQ-011 SHALL have ports out_valid  out  1 / out_ready  in  1: downstream handshake.
REQ-012 SHALL have outputs ac_out  DATA_W, zero_out  1, jump_target  DATA_W, rs_out  DATA_W, rd_out  RD_W, ctrl_out  6.

Function
REQ-013 Accept SHALL occur when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 On accept with ina=1, input accumulator acc_in SHALL load (sin ? imm : reg_val); ALU uses acc_in value before this load.
REQ-015 ALU result r = f(reg_val, acc_in): 000 add, 001 sub (reg_val-acc_in), 010 and, 011 or, 100 xor, 101 signed less-than (1/0), 110 reg_val<<1, 111 see REQ-024; all mod 2^DATA_W.
REQ-016 On completion with sout=1, ac_out SHALL take r and zero_out SHALL take (r==0); with sout=0 both SHALL hold.
REQ-017 jump_target SHALL register pc+imm mod 2^DATA_W; rs_out, rd_out, ctrl_out SHALL register reg_val, rd_in, ctrl_in.
REQ-018 Single-cycle ops: outputs and out_valid=1 SHALL appear the cycle after accept (latency 1).
REQ-019 out_valid SHALL hold, outputs stable, until out_ready=1; clears that cycle unless a new beat completes simultaneously.
REQ-020 FSM states IDLE, MUL: IDLE->MUL on accept of funct 111 (EX_MUL_EN only); MUL->IDLE when iteration count reaches DATA_W, then completion as REQ-018.
REQ-021 flush=1 SHALL clear out_valid, return FSM to IDLE, discard any same-cycle accept; acc_in, ac_out, zero_out SHALL hold.
REQ-022 Back-pressure (out_valid && !out_ready) SHALL deassert in_ready; no beat lost or duplicated.

Reset
REQ-023 resetn=0 SHALL immediately force acc_in, ac_out, jump_target, rs_out=0; zero_out=0; rd_out=0; ctrl_out=0; out_valid=0; state=IDLE; iteration count=0; abort in-progress multiply.

Configuration
REQ-024 Macro EX_MUL_EN defined: funct 111 SHALL be unsigned reg_val*acc_in, low DATA_W bits, shift-add one bit per cycle, result DATA_W+1 cycles after accept, in_ready=0 while in MUL. Undefined: funct 111 SHALL return reg_val in one cycle; MUL state and multiplier logic absent.

Verification
REQ-025 DATA_W=8: reset, then ina=1,sin=1,imm=0x05; next beat funct=000,reg_val=0x03,sout=1 -> ac_out=0x08, zero_out=0, out_valid 1 cycle after accept.
REQ-026 acc_in=0x03, funct=001, reg_val=0x03, sout=1 -> ac_out=0x00, zero_out=1; pc=0xFE, imm=0x04 -> jump_target=0x02 (wrap).
REQ-027 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, one beat delivered once out_ready=1.
REQ-028 EX_MUL_EN: acc_in=0x07, funct=111, reg_val=0x13 -> ac_out=0x85 after 9 cycles, in_ready=0 throughout; without macro -> ac_out=0x13 after 1 cycle.
REQ-029 flush asserted mid-multiply and with simultaneous accept -> out_valid=0, state IDLE, ac_out unchanged; resetn low mid-multiply -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_stage_p.sv
// Execute stage: ALU with input/output accumulators, jump-target adder and a
// valid/ready handshake. Define EX_MUL_EN to add a shift-add multiplier on funct 111.
module ex_stage_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_W   = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        funct,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              sin,
  input  logic              ina,
  input  logic              sout,
  input  logic [5:0]        ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ac_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] rs_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [5:0]        ctrl_out
);

  logic [DATA_W-1:0] accInQ;
  logic [DATA_W-1:0] acOutQ;
  logic              zeroQ;
  logic [DATA_W-1:0] jumpTargetQ;
  logic [DATA_W-1:0] rsQ;
  logic [RD_W-1:0]   rdQ;
  logic [5:0]        ctrlQ;
  logic              outValidQ;

  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] aluRes;
  logic [DATA_W-1:0] resVal;
  logic              resSout;

  // Single-cycle ALU; always reads the accumulator value from before this beat's load.
  always_comb begin
    aluRes = '0;
    unique case (funct)
      3'b000:  aluRes = reg_val + accInQ;
      3'b001:  aluRes = reg_val - accInQ;
      3'b010:  aluRes = reg_val & accInQ;
      3'b011:  aluRes = reg_val | accInQ;
      3'b100:  aluRes = reg_val ^ accInQ;
      3'b101:  aluRes = {{(DATA_W-1){1'b0}}, $signed(reg_val) < $signed(accInQ)};
      3'b110:  aluRes = {reg_val[DATA_W-2:0], 1'b0};
      default: aluRes = reg_val;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  MUL   = 1'b1;

  logic [0:0]        stateQ;
  logic [CNT_W-1:0]  mulCntQ;
  logic [DATA_W-1:0] mcandQ;
  logic [DATA_W-1:0] mplierQ;
  logic [DATA_W-1:0] prodQ;
  logic              mulSoutQ;
  logic              mulStart;
  logic              mulDone;

  assign in_ready = (stateQ == IDLE) && (!outValidQ || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign mulStart = accept && (funct == 3'b111);
  assign mulDone  = (stateQ == MUL) && (mulCntQ == CNT_W'(DATA_W)) && !flush;
  assign complete = (accept && !mulStart) || mulDone;
  assign resVal   = mulDone ? prodQ : aluRes;
  assign resSout  = mulDone ? mulSoutQ : sout;

  // One multiplier bit per cycle; the extra cycle at count==DATA_W is the completion.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateQ   <= IDLE;
      mulCntQ  <= '0;
      mcandQ   <= '0;
      mplierQ  <= '0;
      prodQ    <= '0;
      mulSoutQ <= 1'b0;
    end else if (flush) begin
      stateQ  <= IDLE;
      mulCntQ <= '0;
    end else if (mulStart) begin
      stateQ   <= MUL;
      mulCntQ  <= '0;
      mcandQ   <= reg_val;
      mplierQ  <= accInQ;
      prodQ    <= '0;
      mulSoutQ <= sout;
    end else if (stateQ == MUL) begin
      if (mulDone) begin
        stateQ  <= IDLE;
        mulCntQ <= '0;
      end else begin
        if (mplierQ[0]) begin
          prodQ <= prodQ + mcandQ;
        end
        mcandQ  <= {mcandQ[DATA_W-2:0], 1'b0};
        mplierQ <= {1'b0, mplierQ[DATA_W-1:1]};
        mulCntQ <= mulCntQ + CNT_W'(1);
      end
    end
  end
`else
  assign in_ready = !outValidQ || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign complete = accept;
  assign resVal   = aluRes;
  assign resSout  = sout;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      accInQ      <= '0;
      acOutQ      <= '0;
      zeroQ       <= 1'b0;
      jumpTargetQ <= '0;
      rsQ         <= '0;
      rdQ         <= '0;
      ctrlQ       <= '0;
      outValidQ   <= 1'b0;
    end else begin
      if (accept && ina) begin
        accInQ <= sin ? imm : reg_val;
      end
      if (complete && resSout) begin
        acOutQ <= resVal;
        zeroQ  <= (resVal == '0);
      end
      // Side-band fields are captured at accept; out_valid is low while a multiply runs.
      if (accept) begin
        jumpTargetQ <= pc + imm;
        rsQ         <= reg_val;
        rdQ         <= rd_in;
        ctrlQ       <= ctrl_in;
      end
      if (flush) begin
        outValidQ <= 1'b0;
      end else if (complete) begin
        outValidQ <= 1'b1;
      end else if (out_ready) begin
        outValidQ <= 1'b0;
      end
    end
  end

  assign out_valid   = outValidQ;
  assign ac_out      = acOutQ;
  assign zero_out    = zeroQ;
  assign jump_target = jumpTargetQ;
  assign rs_out      = rsQ;
  assign rd_out      = rdQ;
  assign ctrl_out    = ctrlQ;

endmodule

// File: tb/tb_ex_stage_p.sv
// Self-checking bench for ex_stage_p: directed scenarios plus random traffic against a
// transaction-level reference model. Honours EX_MUL_EN when defined.
module tb_ex_stage_p;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         resetn;
  logic         in_valid, in_ready;
  logic [W-1:0] pc, reg_val, imm;
  logic [2:0]   funct;
  logic [1:0]   rd_in;
  logic         sin, ina, sout;
  logic [5:0]   ctrl_in;
  logic         flush;
  logic         out_valid, out_ready;
  logic [W-1:0] ac_out, jump_target, rs_out;
  logic         zero_out;
  logic [1:0]   rd_out;
  logic [5:0]   ctrl_out;

  ex_stage_p #(.DATA_W(W), .RD_W(2)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .reg_val(reg_val), .imm(imm), .funct(funct), .rd_in(rd_in),
    .sin(sin), .ina(ina), .sout(sout), .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ac_out(ac_out), .zero_out(zero_out),
    .jump_target(jump_target), .rs_out(rs_out), .rd_out(rd_out), .ctrl_out(ctrl_out)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_acc, m_ac, m_jt, m_rs, m_prod;
  logic         m_zero, m_valid, m_psout;
  logic [1:0]   m_rd;
  logic [5:0]   m_ctrl;
  int           m_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sa, sb;
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    case (f)
      3'd0: return W'(int'(a) + int'(b));
      3'd1: return W'(int'(a) - int'(b));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? W'(1) : W'(0);
      3'd6: return W'(int'(a) * 2);
`ifdef EX_MUL_EN
      default: return W'(int'(a) * int'(b));
`else
      default: return a;
`endif
    endcase
  endfunction

  task automatic model_reset();
    m_acc = '0; m_ac = '0; m_jt = '0; m_rs = '0; m_prod = '0;
    m_zero = 1'b0; m_valid = 1'b0; m_psout = 1'b0; m_rd = '0; m_ctrl = '0; m_busy = 0;
  endtask

  task automatic check_zeroed(input string tag);
    check_eq({tag, "_ac"}, ac_out, 0);
    check_eq({tag, "_zero"}, zero_out, 0);
    check_eq({tag, "_jt"}, jump_target, 0);
    check_eq({tag, "_rs"}, rs_out, 0);
    check_eq({tag, "_rd"}, rd_out, 0);
    check_eq({tag, "_ctrl"}, ctrl_out, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("ac_out", ac_out, m_ac);
    check_eq("zero_out", zero_out, m_zero);
    if (m_valid) begin
      check_eq("jump_target", jump_target, m_jt);
      check_eq("rs_out", rs_out, m_rs);
      check_eq("rd_out", rd_out, m_rd);
      check_eq("ctrl_out", ctrl_out, m_ctrl);
    end
  endtask

  // Inputs are set at a negedge; this checks in_ready, clocks once and checks outputs.
  task automatic cycle();
    logic         exp_ready, acc, done, rsout, mul_op;
    logic [W-1:0] r, res;
    #1;
    exp_ready = (m_busy == 0) && (!m_valid || out_ready);
    check_eq("in_ready", in_ready, exp_ready);
    @(posedge clock);
    acc = in_valid && exp_ready && !flush;
    done = 1'b0; res = '0; rsout = 1'b0;
    if (flush) begin
      m_valid = 1'b0;
      m_busy  = 0;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          done = 1'b1; res = m_prod; rsout = m_psout;
        end
      end else if (acc) begin
        r = ref_alu(funct, reg_val, m_acc);
        m_jt = W'(int'(pc) + int'(imm));
        m_rs = reg_val; m_rd = rd_in; m_ctrl = ctrl_in;
        mul_op = 1'b0;
`ifdef EX_MUL_EN
        mul_op = (funct == 3'd7);
`endif
        if (mul_op) begin
          m_busy = W + 1; m_prod = r; m_psout = sout;
        end else begin
          done = 1'b1; res = r; rsout = sout;
        end
        if (ina) m_acc = sin ? imm : reg_val;
      end
      if (done) begin
        m_valid = 1'b1;
        if (rsout) begin
          m_ac = res; m_zero = (res == '0);
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_beat(input logic v, input logic [2:0] f, input logic [W-1:0] rv,
                          input logic [W-1:0] im, input logic s_in, input logic i_na,
                          input logic s_out);
    in_valid = v; funct = f; reg_val = rv; imm = im; sin = s_in; ina = i_na; sout = s_out;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 0; pc = 0; reg_val = 0; imm = 0; funct = 0; rd_in = 0;
    sin = 0; ina = 0; sout = 0; ctrl_in = 0; flush = 0; out_ready = 1;
    model_reset();
    #2;
    check_zeroed("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Load acc_in=5, then add 3 -> 8
    set_beat(1, 3'd0, 8'h00, 8'h05, 1, 1, 0);
    cycle();
    set_beat(1, 3'd0, 8'h03, 8'h00, 0, 0, 1);
    rd_in = 2'd2; ctrl_in = 6'h2A;
    cycle();
    check_eq("add_ac", ac_out, 8'h08);
    check_eq("add_zero", zero_out, 0);
    check_eq("add_valid", out_valid, 1);

    // Sub to zero, jump target wrap
    set_beat(1, 3'd0, 8'h00, 8'h03, 1, 1, 0);
    cycle();
    set_beat(1, 3'd1, 8'h03, 8'h04, 0, 0, 1);
    pc = 8'hFE;
    cycle();
    check_eq("sub_ac", ac_out, 8'h00);
    check_eq("sub_zero", zero_out, 1);
    check_eq("jt_wrap", jump_target, 8'h02);

    // Back-pressure: three stalled cycles then release
    out_ready = 0;
    set_beat(1, 3'd3, 8'h51, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("bp_ready", in_ready, 0);
    out_ready = 1;
    cycle();
    cycle();

    // Multiply 0x13 * 7
    set_beat(1, 3'd0, 8'h00, 8'h07, 1, 1, 0);
    cycle();
    set_beat(1, 3'd7, 8'h13, 8'h00, 0, 0, 1);
    cycle();
    in_valid = 0;
`ifdef EX_MUL_EN
    for (int i = 0; i < int'(W); i++) cycle();
    check_eq("mul_busy", out_valid, 0);
    cycle();
    check_eq("mul_ac", ac_out, 8'h85);
`else
    check_eq("mul_ac", ac_out, 8'h13);
`endif
    check_eq("mul_valid", out_valid, 1);

    // Flush mid-multiply (or mid-stream) together with an offered beat
    set_beat(1, 3'd7, 8'h0B, 8'h00, 0, 0, 1);
    cycle();
    in_valid = 0;
    cycle(); cycle();
    set_beat(1, 3'd0, 8'h44, 8'h09, 1, 1, 1);
    flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ac", ac_out, 8'h85 ^ 8'h85 ^ m_ac);
    cycle(); cycle();

    // Asynchronous reset mid-multiply
    set_beat(1, 3'd7, 8'h21, 8'h00, 0, 0, 1);
    cycle();
    in_valid = 0;
    cycle();
    resetn = 1'b0;
    #1;
    check_zeroed("areset");
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      funct     = 3'($urandom);
      pc        = W'($urandom);
      reg_val   = W'($urandom);
      imm       = W'($urandom);
      rd_in     = 2'($urandom);
      ctrl_in   = 6'($urandom);
      sin       = 1'($urandom);
      ina       = 1'($urandom);
      sout      = 1'($urandom);
      cycle();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 12; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
